// File: rtl/exec_pkg.sv
// Shared types and constants for the executor-side checksum path.
// Holds the arbiter state encoding, result width and default watchdog limit.
package exec_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    localparam int CKSUM_W               = 16;
    localparam int CKSUM_TIMEOUT_DEFAULT = 255;

    // Index width for n lanes; a single lane still needs one bit to hold its id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
// Produces the one-hot grant, the binary lane id and a valid flag.
module rr_picker
    import exec_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               valid
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = 0;
        idx_w = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = (int'(ptr) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!valid && req[idx_w]) begin
                valid        = 1'b1;
                id           = idx_w;
                grant[idx_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cksum_arbiter.sv
// Shares one checksum engine between NUM_REQ lanes: round-robin grant, launch,
// wait for ready (with watchdog), return the result to the owning lane.
module cksum_arbiter
    import exec_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = CKSUM_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_field_start_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_field_len_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic [CKSUM_W-1:0]        cksum_val_o,
    output logic                      busy_o,
    output logic                      cks_start_o,
    output logic [ADDR_W-1:0]         cks_field_start_o,
    output logic [LEN_W-1:0]          cks_field_len_o,
    input  logic                      cks_ready_i,
    input  logic [CKSUM_W-1:0]        cks_val_i
);

    localparam int                ID_W     = id_width(NUM_REQ);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]   PTR_INIT = ID_W'(NUM_REQ - 1);

    arb_state_t         state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [ID_W-1:0]    id, id_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               dropped, dropped_n;
    logic               lost;

    logic [NUM_REQ-1:0] grant_n, done_n, err_n;
    logic [CKSUM_W-1:0] val_n;
    logic               busy_n, start_n;
    logic [ADDR_W-1:0]  fstart_n;
    logic [LEN_W-1:0]   flen_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .id    (pick_id),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ARB_IDLE;
            ptr               <= PTR_INIT;
            id                <= '0;
            cnt               <= '0;
            dropped           <= 1'b0;
            grant_o           <= '0;
            done_o            <= '0;
            err_o             <= '0;
            cksum_val_o       <= '0;
            busy_o            <= 1'b0;
            cks_start_o       <= 1'b0;
            cks_field_start_o <= '0;
            cks_field_len_o   <= '0;
        end else begin
            state             <= state_n;
            ptr               <= ptr_n;
            id                <= id_n;
            cnt               <= cnt_n;
            dropped           <= dropped_n;
            grant_o           <= grant_n;
            done_o            <= done_n;
            err_o             <= err_n;
            cksum_val_o       <= val_n;
            busy_o            <= busy_n;
            cks_start_o       <= start_n;
            cks_field_start_o <= fstart_n;
            cks_field_len_o   <= flen_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        id_n      = id;
        cnt_n     = cnt;
        dropped_n = dropped;
        grant_n   = grant_o;
        done_n    = '0;
        err_n     = '0;
        val_n     = cksum_val_o;
        start_n   = 1'b0;
        fstart_n  = cks_field_start_o;
        flen_n    = cks_field_len_o;
        // A lane that lets go of req while its job runs gets no result pulse.
        lost      = dropped | ~req_i[id];

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_n   = ARB_ISSUE;
                    ptr_n     = pick_id;
                    id_n      = pick_id;
                    cnt_n     = '0;
                    dropped_n = 1'b0;
                    grant_n   = pick_grant;
                    start_n   = 1'b1;
                    fstart_n  = req_field_start_i[int'(pick_id)*ADDR_W +: ADDR_W];
                    flen_n    = req_field_len_i[int'(pick_id)*LEN_W +: LEN_W];
                end
            end
            ARB_ISSUE: begin
                // Engine ready here belongs to a previous job; ignore it.
                state_n   = ARB_WAIT;
                dropped_n = lost;
            end
            ARB_WAIT: begin
                cnt_n     = cnt + CNT_W'(1);
                dropped_n = lost;
                if (cks_ready_i) begin
                    state_n = ARB_DONE;
                    grant_n = '0;
                    if (!lost) begin
                        done_n[id] = 1'b1;
                        val_n      = cks_val_i;
                    end
                end else if (cnt_n == CNT_LAST) begin
                    state_n = ARB_DONE;
                    grant_n = '0;
                    if (!lost) begin
                        err_n[id] = 1'b1;
                        val_n     = '0;
                    end
                end
            end
            ARB_DONE: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase

        busy_n = (state_n != ARB_IDLE);
    end

endmodule

// File: tb/tb_cksum_arbiter.sv
// Bench for cksum_arbiter: directed scenarios plus randomized jobs, checked
// against a transaction-level round-robin / timing model.
module tb_cksum_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int LW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  fstart_bus;
    logic [NR*LW-1:0]  flen_bus;
    logic [NR-1:0]     grant, done, err;
    logic [15:0]       cval;
    logic              busy, cstart;
    logic [AW-1:0]     cfs;
    logic [LW-1:0]     cfl;
    logic              cready;
    logic [15:0]       cvin;

    logic [AW-1:0]     lane_start [NR];
    logic [LW-1:0]     lane_len   [NR];
    int                total = 0;
    int                bad   = 0;
    int                mptr;
    logic [15:0]       mval;
    int                who;

    always #5 clk = ~clk;

    cksum_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .LEN_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_i             (req),
        .req_field_start_i (fstart_bus),
        .req_field_len_i   (flen_bus),
        .grant_o           (grant),
        .done_o            (done),
        .err_o             (err),
        .cksum_val_o       (cval),
        .busy_o            (busy),
        .cks_start_o       (cstart),
        .cks_field_start_o (cfs),
        .cks_field_len_o   (cfl),
        .cks_ready_i       (cready),
        .cks_val_i         (cvin)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_ref(input logic [NR-1:0] r, input int p);
        for (int i = 1; i <= NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    task automatic set_lane(input int i, input logic [AW-1:0] s, input logic [LW-1:0] l);
        lane_start[i] = s;
        lane_len[i]   = l;
        fstart_bus[i*AW +: AW] = s;
        flen_bus[i*LW +: LW]   = l;
    endtask

    task automatic raise(input int i);
        set_lane(i, AW'($urandom), LW'($urandom_range(1, 1500)));
        req[i] = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, "_grant"}, grant, 0);
        chk_eq({tag, "_done"}, done, 0);
        chk_eq({tag, "_err"}, err, 0);
        chk_eq({tag, "_val"}, cval, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_start"}, cstart, 0);
        chk_eq({tag, "_fstart"}, cfs, 0);
        chk_eq({tag, "_flen"}, cfl, 0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        mptr = NR - 1;
        mval = '0;
    endtask

    // Called in an IDLE cycle with at least one request up. mode: 0 ready,
    // 1 never ready (watchdog), 2 winner withdraws req at WAIT cycle wdraw.
    task automatic serve(input int mode, input int lat, input int wdraw, input bit drop,
                         input logic [15:0] v, output int winner);
        int          exp_id;
        int          n_wait;
        logic [15:0] prev;
        exp_id = rr_ref(req, mptr);
        winner = exp_id;
        if (exp_id < 0) begin
            chk_eq("serve_noreq", req, 1);
            return;
        end
        tick();
        chk_eq("issue_start", cstart, 1);
        chk_eq("issue_grant", grant, NR'(1) << exp_id);
        chk_eq("issue_fstart", cfs, lane_start[exp_id]);
        chk_eq("issue_flen", cfl, lane_len[exp_id]);
        chk_eq("issue_busy", busy, 1);
        mptr   = exp_id;
        prev   = mval;
        cready = 1'($urandom_range(0, 1));
        cvin   = 16'($urandom);
        n_wait = (mode == 1) ? TO : lat;
        for (int w = 1; w <= n_wait; w++) begin
            tick();
            cready = 1'b0;
            chk_eq("wait_start", cstart, 0);
            chk_eq("wait_grant", grant, NR'(1) << exp_id);
            chk_eq("wait_pulse", {done, err}, 0);
            chk_eq("wait_busy", busy, 1);
            if (mode == 2 && w == wdraw) req[exp_id] = 1'b0;
            if (mode != 1 && w == lat) begin
                cready = 1'b1;
                cvin   = v;
            end
        end
        tick();
        cready = 1'b0;
        chk_eq("done_grant", grant, 0);
        chk_eq("done_busy", busy, 1);
        chk_eq("done_start", cstart, 0);
        if (mode == 0) begin
            mval = v;
            chk_eq("done_done", done, NR'(1) << exp_id);
            chk_eq("done_err", err, 0);
        end else if (mode == 1) begin
            mval = '0;
            chk_eq("to_err", err, NR'(1) << exp_id);
            chk_eq("to_done", done, 0);
        end else begin
            chk_eq("wd_pulse", {done, err}, 0);
            chk_eq("wd_keep", cval, prev);
        end
        chk_eq("done_val", cval, mval);
        if (drop) req[exp_id] = 1'b0;
        tick();
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_pulse", {done, err, grant}, 0);
    endtask

    initial begin
        rst = 1'b0; req = '0; fstart_bus = '0; flen_bus = '0;
        cready = 1'b0; cvin = '0; mptr = NR - 1; mval = '0;
        for (int i = 0; i < NR; i++) set_lane(i, '0, '0);
        #1 rst = 1'b1;
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Single lane, engine ready three cycles after start.
        set_lane(0, 8'h0E, 32'd20);
        req = 4'b0001;
        serve(0, 3, 0, 1, 16'hB1E6, who);
        chk_eq("t1_who", who, 0);

        // All four lanes from reset, each drops after its done.
        pulse_reset();
        for (int i = 0; i < NR; i++) raise(i);
        for (int k = 0; k < NR; k++) begin
            serve(0, $urandom_range(1, TO), 0, 1, 16'($urandom), who);
            chk_eq("t2_order", who, k);
        end

        // Lanes 1 and 2 hold requests continuously.
        raise(1);
        raise(2);
        for (int k = 0; k < 6; k++) begin
            serve(0, $urandom_range(1, TO), 0, 0, 16'($urandom), who);
            chk_eq("t3_alt", who, (k % 2 == 0) ? 1 : 2);
        end
        req = '0;

        // Watchdog on lane 3 while lane 0 waits, then ready on the limit cycle.
        raise(3);
        raise(0);
        serve(1, 0, 0, 1, 16'h0, who);
        chk_eq("t4_to_who", who, 3);
        serve(0, TO, 0, 1, 16'($urandom), who);
        chk_eq("t4_next", who, 0);

        // Lane 1 withdraws mid-WAIT.
        raise(1);
        serve(2, 6, 3, 0, 16'h1234, who);
        chk_eq("t5_who", who, 1);

        // Reset in the middle of a WAIT.
        raise(2);
        tick();
        tick();
        tick();
        req    = '0;
        cready = 1'b1;
        cvin   = 16'($urandom);
        pulse_reset();
        chk_eq("t6_busy", busy, 0);
        chk_eq("t6_pulse", {done, err, grant, cstart}, 0);
        tick();
        chk_eq("t6_late", {busy, done, err, grant, cstart}, 0);
        cready = 1'b0;
        raise(1);
        raise(2);
        serve(0, $urandom_range(1, TO), 0, 1, 16'($urandom), who);
        chk_eq("t6_first", who, 1);

        // Randomized mix of lanes, latencies and job outcomes.
        for (int j = 0; j < 30; j++) begin
            int m, lat, wd, pick;
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            if (req == '0) raise($urandom_range(0, NR - 1));
            pick = $urandom_range(0, 9);
            m    = (pick < 6) ? 0 : (pick < 8) ? 1 : 2;
            lat  = $urandom_range(1, TO);
            wd   = $urandom_range(1, lat);
            serve(m, lat, wd, 1'($urandom_range(0, 1)), 16'($urandom), who);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
